estagio_busca: RTL and testbench



---
 rtl/riscv_pkg.sv | 28 ++
 rtl/gerador_imediato.sv | 40 ++++
 rtl/estagio_busca.sv | 104 ++++++++++
 tb/tb_estagio_busca.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32 subset definitions for the fetch/decode front end.
// Opcodes, tipo codes, funct3 codes and fetch FSM encoding.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [2:0] TIPO_LW  = 3'b000;
  localparam logic [2:0] TIPO_SW  = 3'b010;
  localparam logic [2:0] TIPO_R   = 3'b011;
  localparam logic [2:0] TIPO_BEQ = 3'b110;

  localparam logic [2:0] F3_SUB = 3'b000;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_SRL = 3'b101;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } estado_t;

endpackage

// File: rtl/gerador_imediato.sv
// Combinational immediate generator and illegal-encoding checker.
// Ports: instr in; imm (sign-extended) and illegal out.
module gerador_imediato #(
  parameter int XLEN = riscv_pkg::XLEN
) (
  input  logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);
  import riscv_pkg::*;

  logic [6:0] opcode;
  logic [2:0] f3;
  logic       unused_rs1;

  assign opcode     = instr[6:0];
  assign f3         = instr[14:12];
  assign unused_rs1 = ^instr[19:15];

  always_comb begin
    imm     = '0;
    illegal = 1'b0;
    unique case (1'b1)
      (opcode == OP_LW):
        imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
      (opcode == OP_SW):
        imm = {{(XLEN-12){instr[31]}},
               instr[31:25], instr[11:7]};
      (opcode == OP_BEQ):
        imm = {{(XLEN-13){instr[31]}},
               instr[31], instr[7],
               instr[30:25], instr[11:8], 1'b0};
      (opcode == OP_R):
        illegal = !(f3 inside {F3_SUB, F3_XOR, F3_SRL});
      default:
        illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/estagio_busca.sv
// Instruction fetch stage: owns PC, fetches over req/rvalid, fills IF/ID.
// Ports: clk, rst_n, imem req/resp, stall, redirect, IF/ID decoded fields.
module estagio_busca #(
  parameter int              XLEN     = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] instr,
  output logic [2:0]      tipo,
  output logic [2:0]      funct3,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);
  import riscv_pkg::*;

  estado_t         estado;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] imm_d;
  logic            illegal_d;

  gerador_imediato #(.XLEN(XLEN)) u_imm (
    .instr   (imem_rdata),
    .imm     (imm_d),
    .illegal (illegal_d)
  );

  // State is forced to REQ during reset, so gate with rst_n
  // to keep the request low while reset is held.
  assign imem_req  = rst_n && (estado == S_REQ);
  assign imem_addr = imem_req ? pc : '0;

  assign tipo   = instr[6:4];
  assign funct3 = instr[14:12];
  assign rd     = instr[11:7];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado   <= S_REQ;
      pc       <= RESET_PC;
      id_valid <= 1'b0;
      id_pc    <= '0;
      instr    <= '0;
      imm      <= '0;
      illegal  <= 1'b0;
    end else if (redirect) begin
      pc       <= redirect_pc;
      id_valid <= 1'b0;
      // A response landing on the redirect edge is simply dropped;
      // otherwise one is still in flight and must be discarded.
      unique case (estado)
        S_WAIT,
        S_DROP:  estado <= imem_rvalid ? S_REQ : S_DROP;
        default: estado <= S_REQ;
      endcase
    end else begin
      unique case (estado)
        S_REQ: begin
          estado <= S_WAIT;
          if (!stall) id_valid <= 1'b0;
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            instr    <= imem_rdata;
            imm      <= imm_d;
            illegal  <= illegal_d;
            id_pc    <= pc;
            pc       <= pc + XLEN'(4);
            id_valid <= 1'b1;
            estado   <= stall ? S_HOLD : S_REQ;
          end else if (!stall) begin
            id_valid <= 1'b0;
          end
        end
        S_HOLD: begin
          if (!stall) begin
            id_valid <= 1'b0;
            estado   <= S_REQ;
          end
        end
        S_DROP: begin
          if (imem_rvalid) estado <= S_REQ;
          if (!stall) id_valid <= 1'b0;
        end
        default: estado <= S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_estagio_busca.sv
// Directed testbench for estagio_busca.
// Hand-computed vectors for fetch, stall, redirect, illegal, reset.
module tb_estagio_busca;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] instr;
  logic [2:0]  tipo;
  logic [2:0]  funct3;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm;
  logic        illegal;

  int checks = 0;
  int errors = 0;

  estagio_busca #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .id_valid    (id_valid),
    .id_pc       (id_pc),
    .instr       (instr),
    .tipo        (tipo),
    .funct3      (funct3),
    .rd          (rd),
    .rs1         (rs1),
    .rs2         (rs2),
    .imm         (imm),
    .illegal     (illegal)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts in REQ; ends one cycle after the response edge.
  task automatic do_fetch(input logic [31:0] w, input logic st);
    step();
    imem_rvalid = 1'b1;
    imem_rdata  = w;
    stall       = st;
    step();
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b want 0", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr got %h want 0", imem_addr); end
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", id_valid); end
    checks++; if (imm !== 32'h0) begin errors++; $display("FAIL rst_imm got %h want 0", imm); end
    checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL rst_illegal got %b want 0", illegal); end
    rst_n = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rel_req got %b want 1", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rel_addr got %h want 0", imem_addr); end
  endtask

  task automatic test_lw();
    do_fetch(32'h0080A283, 1'b0);
    checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL lw_valid got %b want 1", id_valid); end
    checks++; if (tipo !== 3'b000) begin errors++; $display("FAIL lw_tipo got %b want 000", tipo); end
    checks++; if (funct3 !== 3'b010) begin errors++; $display("FAIL lw_f3 got %b want 010", funct3); end
    checks++; if (rd !== 5'd5) begin errors++; $display("FAIL lw_rd got %0d want 5", rd); end
    checks++; if (rs1 !== 5'd1) begin errors++; $display("FAIL lw_rs1 got %0d want 1", rs1); end
    checks++; if (imm !== 32'd8) begin errors++; $display("FAIL lw_imm got %h want 8", imm); end
    checks++; if (id_pc !== 32'h0) begin errors++; $display("FAIL lw_pc got %h want 0", id_pc); end
    checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL lw_illegal got %b want 0", illegal); end
    checks++; if (imem_addr !== 32'h4 || imem_req !== 1'b1) begin errors++; $display("FAIL lw_next got %b/%h want 1/4", imem_req, imem_addr); end
  endtask

  task automatic test_sw_beq();
    step();
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL one_cycle_valid got %b want 0", id_valid); end
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h00512623;
    step();
    imem_rvalid = 1'b0;
    checks++; if (tipo !== 3'b010) begin errors++; $display("FAIL sw_tipo got %b want 010", tipo); end
    checks++; if (rs2 !== 5'd5 || rs1 !== 5'd2) begin errors++; $display("FAIL sw_regs got %0d/%0d want 5/2", rs2, rs1); end
    checks++; if (imm !== 32'd12) begin errors++; $display("FAIL sw_imm got %h want c", imm); end
    checks++; if (id_pc !== 32'h4) begin errors++; $display("FAIL sw_pc got %h want 4", id_pc); end
    do_fetch(32'hFE208CE3, 1'b0);
    checks++; if (tipo !== 3'b110) begin errors++; $display("FAIL beq_tipo got %b want 110", tipo); end
    checks++; if (imm !== 32'hFFFFFFF8) begin errors++; $display("FAIL beq_imm got %h want fffffff8", imm); end
    checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL beq_illegal got %b want 0", illegal); end
    checks++; if (id_pc !== 32'h8) begin errors++; $display("FAIL beq_pc got %h want 8", id_pc); end
  endtask

  task automatic test_stall();
    do_fetch(32'h402081B3, 1'b1);
    for (int i = 0; i < 3; i++) begin
      checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d] got %b want 1", i, id_valid); end
      checks++; if (tipo !== 3'b011 || funct3 !== 3'b000 || rd !== 5'd3) begin errors++; $display("FAIL stall_fields[%0d] got %b/%b/%0d want 011/000/3", i, tipo, funct3, rd); end
      checks++; if (imm !== 32'h0 || id_pc !== 32'hC) begin errors++; $display("FAIL stall_imm_pc[%0d] got %h/%h want 0/c", i, imm, id_pc); end
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_req[%0d] got %b want 0", i, imem_req); end
      if (i < 2) step();
    end
    stall = 1'b0;
    step();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin errors++; $display("FAIL unstall_req got %b/%h want 1/10", imem_req, imem_addr); end
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL unstall_valid got %b want 0", id_valid); end
  endtask

  task automatic test_redirect();
    step();
    redirect    = 1'b1;
    redirect_pc = 32'h40;
    step();
    redirect = 1'b0;
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL redir_valid got %b want 0", id_valid); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL drop_req got %b want 0", imem_req); end
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0080A283;
    step();
    imem_rvalid = 1'b0;
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL stale_valid got %b want 0", id_valid); end
    checks++; if (instr !== 32'h402081B3) begin errors++; $display("FAIL stale_instr got %h want 402081b3", instr); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin errors++; $display("FAIL redir_addr got %b/%h want 1/40", imem_req, imem_addr); end
  endtask

  task automatic test_illegal();
    do_fetch(32'h00100093, 1'b0);
    checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL addi_illegal got %b want 1", illegal); end
    checks++; if (tipo !== 3'b001) begin errors++; $display("FAIL addi_tipo got %b want 001", tipo); end
    checks++; if (id_valid !== 1'b1 || imm !== 32'h0) begin errors++; $display("FAIL addi_valid_imm got %b/%h want 1/0", id_valid, imm); end
    checks++; if (id_pc !== 32'h40) begin errors++; $display("FAIL addi_pc got %h want 40", id_pc); end
    do_fetch(32'h002091B3, 1'b0);
    checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL sll_illegal got %b want 1", illegal); end
    checks++; if (tipo !== 3'b011 || funct3 !== 3'b001) begin errors++; $display("FAIL sll_fields got %b/%b want 011/001", tipo, funct3); end
    checks++; if (id_valid !== 1'b1 || imm !== 32'h0) begin errors++; $display("FAIL sll_valid_imm got %b/%h want 1/0", id_valid, imm); end
    do_fetch(32'h4020C1B3, 1'b0);
    checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL xor_illegal got %b want 0", illegal); end
  endtask

  task automatic test_wrap();
    redirect    = 1'b1;
    redirect_pc = 32'hFFFFFFFC;
    step();
    redirect = 1'b0;
    checks++; if (imem_addr !== 32'hFFFFFFFC) begin errors++; $display("FAIL wrap_addr got %h want fffffffc", imem_addr); end
    do_fetch(32'h0080A283, 1'b0);
    checks++; if (id_pc !== 32'hFFFFFFFC) begin errors++; $display("FAIL wrap_idpc got %h want fffffffc", id_pc); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_next got %h want 0", imem_addr); end
  endtask

  task automatic test_reset_mid();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h0) begin errors++; $display("FAIL mid_req got %b/%h want 0/0", imem_req, imem_addr); end
    checks++; if (id_valid !== 1'b0 || id_pc !== 32'h0) begin errors++; $display("FAIL mid_id got %b/%h want 0/0", id_valid, id_pc); end
    checks++; if (instr !== 32'h0 || imm !== 32'h0 || illegal !== 1'b0) begin errors++; $display("FAIL mid_fields got %h/%h/%b want 0/0/0", instr, imm, illegal); end
    step();
    rst_n = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h00512623;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL post_rst got %b/%h want 1/0", imem_req, imem_addr); end
    step();
    imem_rvalid = 1'b0;
    checks++; if (id_valid !== 1'b0 || instr !== 32'h0) begin errors++; $display("FAIL aborted_resp got %b/%h want 0/0", id_valid, instr); end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw_beq();
    test_stall();
    test_redirect();
    test_illegal();
    test_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
